// File: rtl/seg7led_writer_if.sv
// Bus bundle for seg7led_writer.
//   Update side : in_valid/in_ready handshake carrying in_value (nibble i -> digit i),
//                 in_dp (decimal-point mask), in_enable, in_blank_lz.
//   Register side: m_address/m_write/m_writedata with m_waitrequest stall from the target.
//   Status      : busy.
// modport master is the writer's view (it masters the register bus);
// modport slave is the environment's view (requester + register target).
interface seg7led_writer_if #(
  parameter int unsigned DIGITS = 4
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DIGITS*4-1:0]   in_value;
  logic [DIGITS-1:0]     in_dp;
  logic                  in_enable;
  logic                  in_blank_lz;

  logic [1:0]            m_address;
  logic                  m_write;
  logic [31:0]           m_writedata;
  logic                  m_waitrequest;

  logic                  busy;

  modport master (
    input  in_valid,
    input  in_value,
    input  in_dp,
    input  in_enable,
    input  in_blank_lz,
    input  m_waitrequest,
    output in_ready,
    output m_address,
    output m_write,
    output m_writedata,
    output busy
  );

  modport slave (
    output in_valid,
    output in_value,
    output in_dp,
    output in_enable,
    output in_blank_lz,
    output m_waitrequest,
    input  in_ready,
    input  m_address,
    input  m_write,
    input  m_writedata,
    input  busy
  );

endinterface

// File: rtl/seg7led_writer.sv
// seg7led_writer: turns a display update (hex value, dp mask, enable, leading-zero blanking)
// into up to three register writes on a simple waitrequest bus:
//   address 0 = digit data (DIGITS*4 bits), 1 = digit on mask, 2 = decimal-point mask.
// Each register keeps a shadow of the last value written; a write whose value matches a
// valid shadow is skipped (one idle cycle, no strobe).
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous, active-low reset
//   bus      - seg7led_writer_if.master: update handshake, register bus, busy flag
module seg7led_writer #(
  parameter int unsigned DIGITS = 4
) (
  input logic               clk,
  input logic               reset_n,
  seg7led_writer_if.master  bus
);

  localparam int unsigned DataW = DIGITS * 4;

  typedef enum logic [1:0] {
    StIdle,
    StWrData,
    StWrOn,
    StWrDp
  } state_e;

  state_e state_q, state_d, next_st;

  // Low through reset, high from the first edge after release; gates in_ready.
  logic rdy_q;

  // Captured update
  logic [DataW-1:0]  data_q, data_d;
  logic [DIGITS-1:0] on_q, on_d;
  logic [DIGITS-1:0] dp_q, dp_d;

  // Shadows of the last value actually written to each register
  logic [DataW-1:0]  shd_data_q, shd_data_d;
  logic [DIGITS-1:0] shd_on_q, shd_on_d;
  logic [DIGITS-1:0] shd_dp_q, shd_dp_d;
  logic [2:0]        shd_vld_q, shd_vld_d;

  logic              accept;
  logic [DIGITS-1:0] on_mask;
  logic              any_nz;
  logic              in_write;
  logic              shd_hit;
  logic              skip;
  logic              commit;
  logic [1:0]        addr;
  logic [31:0]       reg_val;
  logic [31:0]       shd_val;

  assign bus.in_ready = rdy_q & (state_q == StIdle);
  assign bus.busy     = (state_q != StIdle);
  assign accept       = bus.in_valid & bus.in_ready;

  // On mask: walking from the top digit down, a digit lights once any digit at or above
  // it is nonzero; the units digit always lights so zero still shows "0".
  always_comb begin
    on_mask = '0;
    any_nz  = 1'b0;
    if (bus.in_enable) begin
      if (!bus.in_blank_lz || DIGITS == 1) begin
        on_mask = '1;
      end else begin
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
          any_nz     = any_nz | (|bus.in_value[i*4 +: 4]);
          on_mask[i] = any_nz;
        end
        on_mask[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    on_d       = on_q;
    dp_d       = dp_q;
    shd_data_d = shd_data_q;
    shd_on_d   = shd_on_q;
    shd_dp_d   = shd_dp_q;
    shd_vld_d  = shd_vld_q;
    reg_val    = '0;
    shd_val    = '0;
    shd_hit    = 1'b0;
    addr       = 2'd0;
    next_st    = StIdle;

    // Select the register handled by the current write state
    unique case (state_q)
      StIdle: begin
      end
      StWrData: begin
        addr                 = 2'd0;
        reg_val[DataW-1:0]   = data_q;
        shd_val[DataW-1:0]   = shd_data_q;
        shd_hit              = shd_vld_q[0];
        next_st              = StWrOn;
      end
      StWrOn: begin
        addr                 = 2'd1;
        reg_val[DIGITS-1:0]  = on_q;
        shd_val[DIGITS-1:0]  = shd_on_q;
        shd_hit              = shd_vld_q[1];
        next_st              = StWrDp;
      end
      StWrDp: begin
        addr                 = 2'd2;
        reg_val[DIGITS-1:0]  = dp_q;
        shd_val[DIGITS-1:0]  = shd_dp_q;
        shd_hit              = shd_vld_q[2];
        next_st              = StIdle;
      end
      default: begin
      end
    endcase

    in_write = (state_q != StIdle);
    skip     = in_write & shd_hit & (reg_val == shd_val);
    commit   = in_write & ~skip & ~bus.m_waitrequest;

    if (state_q == StIdle) begin
      if (accept) begin
        data_d  = bus.in_value;
        dp_d    = bus.in_dp;
        on_d    = on_mask;
        state_d = StWrData;
      end
    end else if (skip || commit) begin
      state_d = next_st;
    end

    // Shadow follows only writes the target actually took
    if (commit) begin
      unique case (state_q)
        StWrData: begin
          shd_data_d   = data_q;
          shd_vld_d[0] = 1'b1;
        end
        StWrOn: begin
          shd_on_d     = on_q;
          shd_vld_d[1] = 1'b1;
        end
        StWrDp: begin
          shd_dp_d     = dp_q;
          shd_vld_d[2] = 1'b1;
        end
        default: begin
        end
      endcase
    end

    // Outputs decode from the async-reset state, so reset drops m_write immediately
    bus.m_write     = in_write & ~skip;
    bus.m_address   = addr;
    bus.m_writedata = in_write ? reg_val : 32'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rdy_q      <= 1'b0;
      data_q     <= '0;
      on_q       <= '0;
      dp_q       <= '0;
      shd_data_q <= '0;
      shd_on_q   <= '0;
      shd_dp_q   <= '0;
      shd_vld_q  <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      data_q     <= data_d;
      on_q       <= on_d;
      dp_q       <= dp_d;
      shd_data_q <= shd_data_d;
      shd_on_q   <= shd_on_d;
      shd_dp_q   <= shd_dp_d;
      shd_vld_q  <= shd_vld_d;
    end
  end

endmodule

// File: tb/tb_seg7led_writer.sv
// Bench for seg7led_writer (DIGITS=4): directed scenarios plus randomized updates with a
// random target stall. Expected register writes come from a digit-level model and sit in a
// queue; a negedge monitor pops and compares each completed bus write.
module tb_seg7led_writer;

  localparam int unsigned DIGITS = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seg7led_writer_if #(.DIGITS(DIGITS)) bus ();

  seg7led_writer #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_shd[3];
  bit          m_vld[3];
  logic [33:0] exp_q[$];

  // Digits from the highest nonzero one down to digit 0 are lit.
  function automatic logic [DIGITS-1:0] model_on(logic [DIGITS*4-1:0] v, bit en, bit blz);
    int top;
    top = 0;
    if (!en) return '0;
    if (!blz) return '1;
    for (int j = 0; j < int'(DIGITS); j++) if (v[j*4 +: 4] != 4'd0) top = j;
    return DIGITS'((1 << (top + 1)) - 1);
  endfunction

  function automatic int model_accept(logic [DIGITS*4-1:0] v, logic [DIGITS-1:0] dp, bit en,
                                      bit blz);
    logic [31:0] regs[3];
    int n;
    n = 0;
    regs[0] = 32'(v);
    regs[1] = 32'(model_on(v, en, blz));
    regs[2] = 32'(dp);
    for (int a = 0; a < 3; a++) begin
      if (!m_vld[a] || m_shd[a] != regs[a]) begin
        exp_q.push_back({2'(a), regs[a]});
        n++;
      end
      m_shd[a] = regs[a];
      m_vld[a] = 1'b1;
    end
    return n;
  endfunction

  // ---------------- target stall driver ----------------
  bit rand_wait  = 1'b0;
  int stall_addr = -1;
  int stall_left = 0;

  initial begin
    bus.m_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && bus.m_write && stall_left > 0 && int'(bus.m_address) == stall_addr) begin
        bus.m_waitrequest = 1'b1;
        stall_left--;
      end else if (rand_wait) begin
        bus.m_waitrequest = ($urandom_range(0, 2) == 0);
      end else begin
        bus.m_waitrequest = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          wr_cyc[3];
  int          stall_cyc = 0;
  int          n_done = 0;
  logic [31:0] last_wd[3];
  bit          hold = 1'b0;
  logic [1:0]  hold_a;
  logic [31:0] hold_d;
  logic [33:0] e;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_write_held", 32'(bus.m_write), 32'd1);
        chk("stall_addr_stable", 32'(bus.m_address), 32'(hold_a));
        chk("stall_data_stable", bus.m_writedata, hold_d);
      end
      if (bus.m_write) begin
        if (bus.m_address < 2'd3) wr_cyc[bus.m_address]++;
        if (bus.m_waitrequest) begin
          stall_cyc++;
          hold   = 1'b1;
          hold_a = bus.m_address;
          hold_d = bus.m_writedata;
        end else begin
          hold = 1'b0;
          n_done++;
          if (bus.m_address < 2'd3) last_wd[bus.m_address] = bus.m_writedata;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h, none expected",
                     bus.m_address, bus.m_writedata);
          end else begin
            e = exp_q.pop_front();
            chk("sb_addr", 32'(bus.m_address), 32'(e[33:32]));
            chk("sb_data", bus.m_writedata, e[31:0]);
          end
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called and returns at posedge+2. Returns cycles from accept to in_ready and busy cycles.
  task automatic send(input logic [15:0] v, input logic [3:0] dp, input bit en, input bit blz,
                      output int lat, output int nexp, output int busy_n);
    int t0;
    int d0;
    busy_n = 0;
    for (int k = 0; k < 200; k++) begin
      if (bus.in_ready) break;
      @(posedge clk);
      #2;
    end
    if (!bus.in_ready) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
    wr_cyc         = '{default: 0};
    stall_cyc      = 0;
    d0             = n_done;
    bus.in_valid    = 1'b1;
    bus.in_value    = v;
    bus.in_dp       = dp;
    bus.in_enable   = en;
    bus.in_blank_lz = blz;
    nexp = model_accept(v, dp, en, blz);
    t0 = cyc;
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.in_ready) break;
      if (bus.busy) busy_n++;
      @(posedge clk);
      #2;
    end
    lat = cyc - t0;
    chk("latency", 32'(lat), 32'(4 + stall_cyc));
    chk("write_count", 32'(n_done - d0), 32'(nexp));
  endtask

  int lat, nexp, busy_n, d0;
  logic [15:0] rv, prev_v;
  logic [3:0]  rdp, prev_dp;

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_value    = '0;
    bus.in_dp       = '0;
    bus.in_enable   = 1'b0;
    bus.in_blank_lz = 1'b0;
    wr_cyc  = '{default: 0};
    last_wd = '{default: 32'd0};
    for (int a = 0; a < 3; a++) begin
      m_shd[a] = '0;
      m_vld[a] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_write", 32'(bus.m_write), 32'd0);
    chk("rst_m_address", 32'(bus.m_address), 32'd0);
    chk("rst_m_writedata", bus.m_writedata, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #2;
    chk("ready_after_edge", 32'(bus.in_ready), 32'd1);

    // First update writes everything
    send(16'h00A5, 4'b0010, 1'b1, 1'b1, lat, nexp, busy_n);
    chk("first_lat", 32'(lat), 32'd4);
    chk("first_data", last_wd[0], 32'h0000_00A5);
    chk("first_on", last_wd[1], 32'h0000_0003);
    chk("first_dp", last_wd[2], 32'h0000_0002);

    // Identical update: all skipped
    send(16'h00A5, 4'b0010, 1'b1, 1'b1, lat, nexp, busy_n);
    chk("repeat_busy", 32'(busy_n), 32'd3);
    chk("repeat_wr_cycles", 32'(wr_cyc[0] + wr_cyc[1] + wr_cyc[2]), 32'd0);

    // Data-only change
    send(16'h00A6, 4'b0010, 1'b1, 1'b1, lat, nexp, busy_n);
    chk("data_only_wr0", 32'(wr_cyc[0]), 32'd1);
    chk("data_only_wr12", 32'(wr_cyc[1] + wr_cyc[2]), 32'd0);
    chk("data_only_val", last_wd[0], 32'h0000_00A6);

    // Two stall cycles on the on-mask write
    stall_addr = 1;
    stall_left = 2;
    send(16'h0AA6, 4'b0010, 1'b1, 1'b1, lat, nexp, busy_n);
    chk("stall_lat", 32'(lat), 32'd6);
    chk("stall_on_cycles", 32'(wr_cyc[1]), 32'd3);
    chk("stall_on_val", last_wd[1], 32'h0000_0007);

    // All-zero value keeps the units digit; disable blanks everything
    send(16'h0000, 4'b0010, 1'b1, 1'b1, lat, nexp, busy_n);
    chk("zero_on", last_wd[1], 32'h0000_0001);
    send(16'h0000, 4'b0010, 1'b0, 1'b1, lat, nexp, busy_n);
    chk("disable_on", last_wd[1], 32'h0000_0000);

    // Reset in the middle of a stalled dp write
    stall_addr      = 2;
    stall_left      = 50;
    bus.in_valid    = 1'b1;
    bus.in_value    = 16'h0000;
    bus.in_dp       = 4'b1000;
    bus.in_enable   = 1'b0;
    bus.in_blank_lz = 1'b1;
    nexp = model_accept(16'h0000, 4'b1000, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.m_write && bus.m_address == 2'd2) break;
      @(posedge clk);
      #2;
    end
    chk("dp_write_reached", 32'(bus.m_write && bus.m_address == 2'd2), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_m_write", 32'(bus.m_write), 32'd0);
    chk("abort_m_address", 32'(bus.m_address), 32'd0);
    chk("abort_m_writedata", bus.m_writedata, 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    for (int a = 0; a < 3; a++) m_vld[a] = 1'b0;
    stall_left = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    send(16'h0000, 4'b1000, 1'b0, 1'b1, lat, nexp, busy_n);
    chk("post_reset_all3", 32'(wr_cyc[0] + wr_cyc[1] + wr_cyc[2]), 32'd3);

    // Randomized updates with a randomly stalling target
    rand_wait = 1'b1;
    prev_v    = 16'h1234;
    prev_dp   = 4'b0101;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0:       rv = prev_v;
        1:       rv = 16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3));
        default: rv = 16'($urandom);
      endcase
      rdp = ($urandom_range(0, 1) == 0) ? prev_dp : 4'($urandom);
      send(rv, rdp, ($urandom_range(0, 4) != 0), 1'($urandom), lat, nexp, busy_n);
      prev_v  = rv;
      prev_dp = rdp;
    end
    rand_wait = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
